alu_seq_ctrl: RTL

Instruction sequencer for the SPI-attached ALU datapath. It accepts packed 20-bit instruction words from the SPI receive side over a valid/ready handshake, buffers them in a small FIFO, and decodes each into opcode/a/b. It drives the ALU's `exec_en`/`a`/`b`/`opcode` for exactly one cycle per instruction, captures the ALU result and returns it, in order, to the SPI transmit side over a valid/ready handshake.

---
 rtl/alu_seq_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer: buffers packed ALU instructions in a FIFO, issues one ALU op per entry
// and returns results in order. Define ALU_SEQ_CTRL_OPCHK_EN to enable the illegal-opcode check.
module alu_seq_ctrl #(
    parameter int unsigned BIT_LENGTH    = 8,
    parameter int unsigned INSTR_LENGTH  = 20,
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    input  logic [INSTR_LENGTH-1:0]  instr,
    output logic                     instr_ready,
    output logic                     res_valid,
    output logic [INSTR_LENGTH-1:0]  res_data,
    output logic                     res_err,
    input  logic                     res_ready,
    output logic                     alu_exec_en,
    output logic [BIT_LENGTH-1:0]    alu_a,
    output logic [BIT_LENGTH-1:0]    alu_b,
    output logic [OPCODE_LENGTH-1:0] alu_opcode,
    input  logic [INSTR_LENGTH-1:0]  alu_out,
    output logic                     busy
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e                   state;
    logic [INSTR_LENGTH-1:0]  mem [FIFO_DEPTH];
    logic [PtrW-1:0]          wr_ptr;
    logic [PtrW-1:0]          rd_ptr;
    logic [CntW-1:0]          count;
    logic                     op_illegal;

    logic                     push;
    logic                     pop;
    logic                     fifo_empty;
    logic                     head_legal;
    logic [INSTR_LENGTH-1:0]  head;
    logic [OPCODE_LENGTH-1:0] head_opcode;

    assign fifo_empty  = (count == '0);
    assign instr_ready = (count != CntW'(FIFO_DEPTH));
    assign push        = instr_valid && instr_ready;
    // The head is consumed either from idle or straight out of a completed response handshake.
    assign pop         = !fifo_empty && ((state == StIdle) || ((state == StResp) && res_ready));
    assign head        = mem[rd_ptr];
    assign head_opcode = head[INSTR_LENGTH-1 -: OPCODE_LENGTH];
    assign busy        = (state != StIdle) || !fifo_empty;

`ifdef ALU_SEQ_CTRL_OPCHK_EN
    assign head_legal = (head_opcode <= OPCODE_LENGTH'(8));
`else
    assign head_legal = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            alu_exec_en <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            op_illegal  <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_err     <= 1'b0;
        end else begin
            alu_exec_en <= 1'b0;
            // Every pop leads into EXEC on the next cycle, so the strobe is set here.
            if (pop) begin
                alu_opcode  <= head_opcode;
                alu_a       <= head[2*BIT_LENGTH-1 -: BIT_LENGTH];
                alu_b       <= head[BIT_LENGTH-1:0];
                op_illegal  <= !head_legal;
                alu_exec_en <= head_legal;
            end
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        state <= StExec;
                    end
                end
                StExec: begin
                    res_data  <= op_illegal ? '0 : alu_out;
                    res_err   <= op_illegal;
                    res_valid <= 1'b1;
                    state     <= StResp;
                end
                StResp: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= pop ? StExec : StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
